// File: rtl/watermark_scheduler.sv
// Streams segment words through a watermark OR-stage, rotating through enabled
// watermark slots at frame boundaries. Two-word output FIFO with credit-based input stall.
module watermark_scheduler #(
    parameter int WIDTH     = 224,
    parameter int HEIGHT    = 96,
    parameter int WORD_W    = 32,
    parameter int NUM_SLOTS = 4,
    localparam int WPF      = WIDTH * HEIGHT / WORD_W,
    localparam int AW       = (NUM_SLOTS * WPF > 1) ? $clog2(NUM_SLOTS * WPF) : 1,
    localparam int SW       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int CW       = (WPF > 1) ? $clog2(WPF) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_enable,
    input  logic [NUM_SLOTS-1:0] cfg_slot_mask,
    input  logic [7:0]           cfg_hold,
    input  logic                 seg_valid,
    output logic                 seg_ready,
    input  logic [WORD_W-1:0]    seg_data,
    input  logic                 seg_last,
    output logic                 wm_rd_en,
    output logic [AW-1:0]        wm_rd_addr,
    input  logic [WORD_W-1:0]    wm_rd_data,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic [WORD_W-1:0]    pix_data,
    output logic                 pix_last,
    output logic [SW-1:0]        cur_slot,
    output logic                 frame_done,
    output logic                 err_framing,
    output logic [1:0]           dbg_state
);

    // Handshakes: a word moves when valid and ready are both 1 in the same cycle;
    // valid never waits on ready, and a raised valid holds its payload until accepted.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [CW-1:0]     word_cnt;
    logic [7:0]        hold_cnt;
    logic              stg_valid, stg_last, stg_use_wm;
    logic [WORD_W-1:0] stg_seg;
    logic [WORD_W-1:0] fifo_data [2];
    logic              fifo_last [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        fifo_cnt;

    logic       mask_any, pop, push, accept, at_end, frame_end, open_frame, pipe_empty, credit;
    logic [2:0] occ;

    function automatic logic [SW-1:0] lowest_slot(input logic [NUM_SLOTS-1:0] mask);
        logic [SW-1:0] r;
        r = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (mask[i]) r = SW'(i);
        return r;
    endfunction

    function automatic logic [SW-1:0] next_slot(input logic [SW-1:0] cur,
                                                input logic [NUM_SLOTS-1:0] mask);
        logic [SW-1:0] r;
        logic          found;
        int            idx;
        r     = cur;
        found = 1'b0;
        for (int i = 1; i <= NUM_SLOTS; i++) begin
            idx = (int'(cur) + i) % NUM_SLOTS;
            if (!found && mask[idx]) begin
                r     = SW'(idx);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign dbg_state  = state;
    assign mask_any   = |cfg_slot_mask;
    assign pix_valid  = (fifo_cnt != 2'd0);
    assign pix_data   = pix_valid ? fifo_data[rd_ptr] : '0;
    assign pix_last   = pix_valid ? fifo_last[rd_ptr] : 1'b0;
    assign pop        = pix_valid && pix_ready;
    assign push       = stg_valid;
    assign frame_done = pop && pix_last;
    assign open_frame = (word_cnt != '0);
    assign pipe_empty = !stg_valid && (fifo_cnt == 2'd0);

    // Occupancy is counted net of this cycle's pop so a full-rate stream never stalls.
    assign occ    = 3'(fifo_cnt) - 3'(pop) + 3'(stg_valid);
    assign credit = (occ < 3'd2);

    // Once enable drops, only the open frame may finish; no new frame is started.
    assign seg_ready = credit && (((state == S_RUN) && (cfg_enable || open_frame)) ||
                                  ((state == S_DRAIN) && open_frame));
    assign accept      = seg_valid && seg_ready;
    assign at_end      = (word_cnt == CW'(WPF - 1));
    assign frame_end   = seg_last || at_end;
    assign err_framing = accept && (seg_last != at_end);
    assign wm_rd_en    = accept && mask_any;
    assign wm_rd_addr  = wm_rd_en ? AW'(int'(cur_slot) * WPF + int'(word_cnt)) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            word_cnt <= '0;
            hold_cnt <= '0;
            cur_slot <= '0;
        end else begin
            case (state)
                S_IDLE: if (cfg_enable) begin
                    state    <= S_RUN;
                    cur_slot <= lowest_slot(cfg_slot_mask);
                    hold_cnt <= '0;
                    word_cnt <= '0;
                end
                S_RUN: if (!cfg_enable) begin
                    if (open_frame) state <= S_DRAIN;
                    else if (pipe_empty) state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (cfg_enable) state <= S_RUN;
                    else if (!open_frame && pipe_empty) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (accept) begin
                if (frame_end) begin
                    word_cnt <= '0;
                    if (hold_cnt == cfg_hold) begin
                        hold_cnt <= '0;
                        cur_slot <= next_slot(cur_slot, cfg_slot_mask);
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end else begin
                    word_cnt <= word_cnt + CW'(1);
                end
            end
        end
    end

    // Stage holds the segment word while the watermark read returns one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid    <= 1'b0;
            stg_last     <= 1'b0;
            stg_use_wm   <= 1'b0;
            stg_seg      <= '0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last[0] <= 1'b0;
            fifo_last[1] <= 1'b0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fifo_cnt     <= 2'd0;
        end else begin
            stg_valid <= accept;
            if (accept) begin
                stg_seg    <= seg_data;
                stg_last   <= frame_end;
                stg_use_wm <= mask_any;
            end
            if (push) begin
                fifo_data[wr_ptr] <= stg_seg | (stg_use_wm ? wm_rd_data : '0);
                fifo_last[wr_ptr] <= stg_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
        end
    end

endmodule
